// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit deframing,
// E0/F0 prefix decoding and held-key tracking.
module ps2_scan_rx #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic [7:0] held_code,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] PRE_EXT = 8'hE0;
    localparam logic [7:0] PRE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          filt_q;
    logic [FW-1:0] flt_cnt_q;
    logic          flip_d;
    logic          fall_d;
    logic          bit_d;

    state_t        state_q;
    logic [3:0]    bitcnt_q;
    logic [9:0]    sr_q;
    logic [TW-1:0] to_cnt_q;
    logic          ext_pend_q;
    logic          brk_pend_q;
    logic [7:0]    code_q;
    logic          valid_q;
    logic          brk_q;
    logic          ext_q;
    logic [7:0]    held_q;
    logic          err_q;

    logic [7:0]    byte_d;
    logic          frame_ok_d;
    logic          bad_d;
    logic          pre_e0_d;
    logic          pre_f0_d;
    logic          key_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample
    assign flip_d = (clk_sync_q[1] != filt_q) && (flt_cnt_q == FLT_LAST);
    assign fall_d = flip_d && filt_q;
    assign bit_d  = dat_sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
        end else begin
            if ((clk_sync_q[1] == filt_q) || flip_d) begin
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FW'(1);
            end
            if (flip_d) begin
                filt_q <= ~filt_q;
            end
        end
    end

    assign byte_d     = sr_q[7:0];
    assign frame_ok_d = (^sr_q[8:0]) && sr_q[9];
    assign bad_d      = !frame_ok_d;
    assign pre_e0_d   = frame_ok_d && (byte_d == PRE_EXT);
    assign pre_f0_d   = frame_ok_d && (byte_d == PRE_BRK);
    assign key_d      = frame_ok_d && !pre_e0_d && !pre_f0_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            sr_q       <= '0;
            to_cnt_q   <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            held_q     <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (fall_d && !bit_d) begin
                        state_q  <= RECV;
                        bitcnt_q <= '0;
                        to_cnt_q <= '0;
                    end
                end
                RECV: begin
                    if (fall_d) begin
                        sr_q     <= {bit_d, sr_q[9:1]};
                        to_cnt_q <= '0;
                        if (bitcnt_q == 4'd9) begin
                            state_q <= CHECK;
                        end else begin
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        err_q      <= 1'b1;
                        ext_pend_q <= 1'b0;
                        brk_pend_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    unique case (1'b1)
                        bad_d: begin
                            err_q      <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end
                        pre_e0_d: ext_pend_q <= 1'b1;
                        pre_f0_d: brk_pend_q <= 1'b1;
                        key_d: begin
                            code_q     <= byte_d;
                            brk_q      <= brk_pend_q;
                            ext_q      <= ext_pend_q;
                            valid_q    <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                            if (!brk_pend_q) begin
                                held_q <= byte_d;
                            end else if (byte_d == held_q) begin
                                held_q <= 8'h00;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign code       = code_q;
    assign code_valid = valid_q;
    assign is_break   = brk_q;
    assign is_ext     = ext_q;
    assign held_code  = held_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Randomised self-checking bench for ps2_scan_rx against a
// byte-level keyboard event model.
module tb_ps2_scan_rx;

    localparam int FL  = 4;
    localparam int TO  = 600;
    localparam int HB  = 25;
    localparam int LAT = 2 + FL + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_ext;
    logic [7:0] held_code;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both = 0;
    int vcyc = 0;
    int stop_cyc = 0;

    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [7:0] m_held = 8'h00;
    logic [7:0] e_code = 8'h00;
    logic       e_brk = 1'b0;
    logic       e_ext = 1'b0;
    int         e_v = 0;
    int         e_e = 0;
    int         dv = 0;
    int         de = 0;

    ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code(code), .code_valid(code_valid),
        .is_break(is_break), .is_ext(is_ext),
        .held_code(held_code), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (code_valid) begin
                vcnt <= vcnt + 1;
                vcyc <= cyc;
            end
            if (frame_err) ecnt <= ecnt + 1;
            if (code_valid && frame_err) both <= both + 1;
        end
    end

    task automatic model_byte(input logic [7:0] b, input bit badp);
        e_v = 0;
        e_e = 0;
        if (badp) begin
            e_e = 1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            e_v = 1;
            e_code = b;
            e_brk = m_brk;
            e_ext = m_ext;
            if (!m_brk) m_held = b;
            else if (b == m_held) m_held = 8'h00;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HB) @(negedge clk);
            if (i == 10) stop_cyc = cyc;
            ps2_clk = 1'b0;
            repeat (HB) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HB) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] b, input bit badp);
        logic       par;
        int         v0;
        int         e0;
        par = ~(^b) ^ badp;
        v0 = vcnt;
        e0 = ecnt;
        model_byte(b, badp);
        send_bits({1'b1, par, b, 1'b0}, 11);
        dv = vcnt - v0;
        de = ecnt - e0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({code, code_valid, is_break, is_ext, held_code, frame_err} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                {code, code_valid, is_break, is_ext, held_code, frame_err});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (code_valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got v=%b e=%b want 0 0", code_valid, frame_err);
        end
    endtask

    task automatic test_make;
        xfer(8'h1C, 1'b0);
        total++;
        if (dv != 1 || de != 0) begin
            bad++;
            $display("FAIL make_pulses got v=%0d e=%0d want 1 0", dv, de);
        end
        total++;
        if ({code, is_break, is_ext} !== {8'h1C, 2'b00}) begin
            bad++;
            $display("FAIL make_code got=%h/%b/%b want 1c/0/0", code, is_break, is_ext);
        end
        total++;
        if (held_code !== 8'h1C) begin
            bad++;
            $display("FAIL make_held got=%h want 1c", held_code);
        end
        total++;
        if (vcyc - stop_cyc != LAT) begin
            bad++;
            $display("FAIL make_latency got=%0d want=%0d", vcyc - stop_cyc, LAT);
        end
    endtask

    task automatic test_break;
        xfer(8'hF0, 1'b0);
        total++;
        if (dv != 0 || de != 0) begin
            bad++;
            $display("FAIL brk_prefix got v=%0d e=%0d want 0 0", dv, de);
        end
        xfer(8'h1C, 1'b0);
        total++;
        if (dv != 1 || code !== 8'h1C || is_break !== 1'b1 || is_ext !== 1'b0) begin
            bad++;
            $display("FAIL brk_event got v=%0d c=%h b=%b x=%b want 1 1c 1 0",
                dv, code, is_break, is_ext);
        end
        total++;
        if (held_code !== 8'h00) begin
            bad++;
            $display("FAIL brk_held got=%h want 00", held_code);
        end
    endtask

    task automatic test_ext;
        xfer(8'hE0, 1'b0);
        xfer(8'h6B, 1'b0);
        total++;
        if (code !== 8'h6B || is_ext !== 1'b1 || is_break !== 1'b0 ||
            held_code !== 8'h6B) begin
            bad++;
            $display("FAIL ext_make got c=%h x=%b b=%b h=%h want 6b 1 0 6b",
                code, is_ext, is_break, held_code);
        end
        xfer(8'hE0, 1'b0);
        xfer(8'hF0, 1'b0);
        xfer(8'h6B, 1'b0);
        total++;
        if (dv != 1 || is_ext !== 1'b1 || is_break !== 1'b1 || held_code !== 8'h00) begin
            bad++;
            $display("FAIL ext_break got v=%0d x=%b b=%b h=%h want 1 1 1 00",
                dv, is_ext, is_break, held_code);
        end
    endtask

    task automatic test_parity;
        logic [7:0] h0;
        h0 = held_code;
        xfer(8'h72, 1'b1);
        total++;
        if (dv != 0 || de != 1 || held_code !== h0) begin
            bad++;
            $display("FAIL parity_err got v=%0d e=%0d h=%h want 0 1 %h",
                dv, de, held_code, h0);
        end
        xfer(8'h72, 1'b0);
        total++;
        if (dv != 1 || de != 0 || code !== 8'h72 || held_code !== 8'h72) begin
            bad++;
            $display("FAIL parity_ok got v=%0d e=%0d c=%h h=%h want 1 0 72 72",
                dv, de, code, held_code);
        end
    endtask

    task automatic test_timeout;
        int v0;
        int e0;
        v0 = vcnt;
        e0 = ecnt;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
        repeat (TO + 20) @(negedge clk);
        total++;
        if (vcnt - v0 != 0 || ecnt - e0 != 1) begin
            bad++;
            $display("FAIL timeout got v=%0d e=%0d want 0 1", vcnt - v0, ecnt - e0);
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
        xfer(8'h1C, 1'b0);
        total++;
        if (dv != 1 || de != 0 || code !== 8'h1C || held_code !== 8'h1C) begin
            bad++;
            $display("FAIL timeout_recover got v=%0d e=%0d c=%h h=%h want 1 0 1c 1c",
                dv, de, code, held_code);
        end
    endtask

    task automatic test_glitch;
        int v0;
        int e0;
        v0 = vcnt;
        e0 = ecnt;
        ps2_data = 1'b0;
        repeat (HB) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HB) @(negedge clk);
        xfer(8'h2B, 1'b0);
        total++;
        if (vcnt - v0 != 1 || ecnt - e0 != 0 || code !== 8'h2B) begin
            bad++;
            $display("FAIL glitch got v=%0d e=%0d c=%h want 1 0 2b",
                vcnt - v0, ecnt - e0, code);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        int e0;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
        v0 = vcnt;
        e0 = ecnt;
        reset = 1'b1;
        #1;
        total++;
        if ({code, code_valid, is_break, is_ext, held_code, frame_err} !== 20'h0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=0",
                {code, code_valid, is_break, is_ext, held_code, frame_err});
        end
        repeat (4) @(negedge clk);
        reset = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_held = 8'h00;
        repeat (4) @(negedge clk);
        xfer(8'h6B, 1'b0);
        total++;
        if (vcnt - v0 != 1 || ecnt - e0 != 0 || code !== 8'h6B || held_code !== 8'h6B) begin
            bad++;
            $display("FAIL reset_recover got v=%0d e=%0d c=%h h=%h want 1 0 6b 6b",
                vcnt - v0, ecnt - e0, code, held_code);
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        bit         bp;
        int         r;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 5);
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r == 2) b = m_held;
            else b = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 7) == 0);
            xfer(b, bp);
            total++;
            if (dv != e_v || de != e_e || held_code !== m_held) begin
                bad++;
                $display("FAIL rnd%0d_pulse b=%h got v=%0d e=%0d h=%h want %0d %0d %h",
                    i, b, dv, de, held_code, e_v, e_e, m_held);
            end
            if (e_v == 1) begin
                total++;
                if ({code, is_break, is_ext} !== {e_code, e_brk, e_ext}) begin
                    bad++;
                    $display("FAIL rnd%0d_code got=%h/%b/%b want %h/%b/%b",
                        i, code, is_break, is_ext, e_code, e_brk, e_ext);
                end
            end
        end
    endtask

    task automatic test_exclusive;
        total++;
        if (both != 0) begin
            bad++;
            $display("FAIL exclusive got=%0d want=0 cycles with both pulses", both);
        end
    endtask

    initial begin
        test_reset;
        test_make;
        test_break;
        test_ext;
        test_parity;
        test_timeout;
        test_glitch;
        test_reset_mid;
        test_random;
        test_exclusive;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
